// File: rtl/l1_l2_req_arbiter_pkg.sv
// Shared types for the L1->L2 request arbiter: L2 opcodes, FSM states, source ids.
package l1_l2_req_arbiter_pkg;

  typedef enum logic [1:0] {
    L2_READ  = 2'd0,
    L2_RFO   = 2'd1,
    L2_WRITE = 2'd2
  } l2_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  localparam logic SRC_DC = 1'b0;
  localparam logic SRC_IC = 1'b1;

  function automatic logic is_writeback(input logic [1:0] op);
    return l2_op_e'(op) == L2_WRITE;
  endfunction

endpackage

// File: rtl/l1_l2_req_arbiter_rr_grant.sv
// 2-way round-robin grant between D-cache and I-cache; a D-cache writeback always wins.
// Purely combinational; no grant at all while i_en is low.
module l1_rr_grant
  import l1_l2_req_arbiter_pkg::*;
(
  input  logic i_en,
  input  logic i_dc_vld,
  input  logic i_dc_wr,
  input  logic i_ic_vld,
  input  logic i_last_grant,
  output logic o_gnt_dc,
  output logic o_gnt_ic
);

  always_comb begin
    o_gnt_dc = 1'b0;
    o_gnt_ic = 1'b0;
    if (i_en) begin
      if (i_dc_vld && i_dc_wr) begin
        o_gnt_dc = 1'b1;
      end else if (i_dc_vld && i_ic_vld) begin
        // Contention: favour whichever side did not win last time.
        if (i_last_grant == SRC_DC) o_gnt_ic = 1'b1;
        else                        o_gnt_dc = 1'b1;
      end else if (i_dc_vld) begin
        o_gnt_dc = 1'b1;
      end else if (i_ic_vld) begin
        o_gnt_ic = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_l2_req_arbiter.sv
// Shares the L1->L2 request channel between D-cache and I-cache, one transaction in flight.
// Optional grant statistics counters are enabled with the L1_ARB_STATS_EN macro.
module l1_l2_req_arbiter
  import l1_l2_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef L1_ARB_STATS_EN
  ,parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dc_req_valid,
  input  logic [1:0]        dc_req_op,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  output logic              dc_rsp_valid,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_rsp_valid,
  input  logic              l2_snoop_active,
  output logic              l2_req_valid,
  output logic [1:0]        l2_req_op,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic              l2_req_src,
  input  logic              l2_req_ready,
  input  logic              l2_rsp_valid,
  output logic              proto_err
`ifdef L1_ARB_STATS_EN
  ,output logic [CNT_W-1:0] dc_grant_cnt
  ,output logic [CNT_W-1:0] ic_grant_cnt
  ,output logic [CNT_W-1:0] wb_grant_cnt
`endif
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_grant;
  l2_op_e            r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_src;
  logic              r_dc_rsp;
  logic              r_ic_rsp;
  logic              r_proto_err;

  logic w_grant_en;
  logic w_dc_wr;
  logic w_gnt_dc;
  logic w_gnt_ic;
  logic w_accept;
  logic w_rsp_done;

  assign w_grant_en = (r_state == IDLE) && !l2_snoop_active;
  assign w_dc_wr    = is_writeback(dc_req_op);
  assign w_accept   = w_gnt_dc | w_gnt_ic;
  assign w_rsp_done = (r_state == WAIT_RSP) && l2_rsp_valid;

  l1_rr_grant u_rr_grant (
    .i_en         (w_grant_en),
    .i_dc_vld     (dc_req_valid),
    .i_dc_wr      (w_dc_wr),
    .i_ic_vld     (ic_req_valid),
    .i_last_grant (r_last_grant),
    .o_gnt_dc     (w_gnt_dc),
    .o_gnt_ic     (w_gnt_ic)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_accept)     w_state_nxt = ISSUE;
      ISSUE:    if (l2_req_ready) w_state_nxt = WAIT_RSP;
      WAIT_RSP: if (l2_rsp_valid) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Captured request is held until the next grant so op/addr stay stable through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= SRC_IC;
      r_op         <= L2_READ;
      r_addr       <= '0;
      r_src        <= SRC_DC;
    end else if (w_gnt_dc) begin
      r_last_grant <= SRC_DC;
      r_op         <= l2_op_e'(dc_req_op);
      r_addr       <= dc_req_addr;
      r_src        <= SRC_DC;
    end else if (w_gnt_ic) begin
      r_last_grant <= SRC_IC;
      r_op         <= L2_READ;
      r_addr       <= ic_req_addr;
      r_src        <= SRC_IC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dc_rsp    <= 1'b0;
      r_ic_rsp    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_dc_rsp    <= w_rsp_done && (r_src == SRC_DC);
      r_ic_rsp    <= w_rsp_done && (r_src == SRC_IC);
      // A completion with nothing outstanding means L2 and L1 have lost sync.
      r_proto_err <= r_proto_err | (l2_rsp_valid && (r_state != WAIT_RSP));
    end
  end

  assign dc_req_ready = w_gnt_dc;
  assign ic_req_ready = w_gnt_ic;
  assign dc_rsp_valid = r_dc_rsp;
  assign ic_rsp_valid = r_ic_rsp;
  assign l2_req_valid = (r_state == ISSUE);
  assign l2_req_op    = r_op;
  assign l2_req_addr  = r_addr;
  assign l2_req_src   = r_src;
  assign proto_err    = r_proto_err;

`ifdef L1_ARB_STATS_EN
  logic [CNT_W-1:0] r_dc_cnt;
  logic [CNT_W-1:0] r_ic_cnt;
  logic [CNT_W-1:0] r_wb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dc_cnt <= '0;
      r_ic_cnt <= '0;
      r_wb_cnt <= '0;
    end else begin
      if (w_gnt_dc && (r_dc_cnt != '1))            r_dc_cnt <= r_dc_cnt + CNT_W'(1);
      if (w_gnt_ic && (r_ic_cnt != '1))            r_ic_cnt <= r_ic_cnt + CNT_W'(1);
      if (w_gnt_dc && w_dc_wr && (r_wb_cnt != '1)) r_wb_cnt <= r_wb_cnt + CNT_W'(1);
    end
  end

  assign dc_grant_cnt = r_dc_cnt;
  assign ic_grant_cnt = r_ic_cnt;
  assign wb_grant_cnt = r_wb_cnt;
`endif

endmodule
